// File: rtl/ex_stage_if.sv
// Bundle of the ID/EX inputs, WB forwarding inputs, fetch redirect and EX/MEM
// register outputs of the RV32I execute stage.
interface ex_stage_if #(
  parameter int XLEN    = 32,
  parameter int REGADDR = 5
);
  logic               flush_m;
  logic               reg_wr_e;
  logic [1:0]         res_src_e;
  logic               mem_wr_e;
  logic               pc_src2_e;
  logic [2:0]         alu_control_e;
  logic               alu_src_e;
  logic [XLEN-1:0]    rd1_e;
  logic [XLEN-1:0]    rd2_e;
  logic [XLEN-1:0]    pc_e;
  logic [XLEN-1:0]    imm_e;
  logic [XLEN-1:0]    pc_plus4_e;
  logic [REGADDR-1:0] rs1_e;
  logic [REGADDR-1:0] rs2_e;
  logic [REGADDR-1:0] rd_e;
  logic [6:0]         op_e;
  logic [2:0]         f3_e;
  logic [REGADDR-1:0] rd_w;
  logic               reg_wr_w;
  logic [XLEN-1:0]    result_w;
  logic               pc_src;
  logic [XLEN-1:0]    pc_target;
  logic               reg_wr_m;
  logic               mem_wr_m;
  logic [1:0]         res_src_m;
  logic [XLEN-1:0]    alu_result_m;
  logic [XLEN-1:0]    write_data_m;
  logic [XLEN-1:0]    pc_plus4_m;
  logic [XLEN-1:0]    imm_m;
  logic [REGADDR-1:0] rd_m;
  logic [2:0]         f3_m;

  modport master (
    output flush_m, reg_wr_e, res_src_e, mem_wr_e, pc_src2_e, alu_control_e,
           alu_src_e, rd1_e, rd2_e, pc_e, imm_e, pc_plus4_e, rs1_e, rs2_e,
           rd_e, op_e, f3_e, rd_w, reg_wr_w, result_w,
    input  pc_src, pc_target, reg_wr_m, mem_wr_m, res_src_m, alu_result_m,
           write_data_m, pc_plus4_m, imm_m, rd_m, f3_m
  );

  modport slave (
    input  flush_m, reg_wr_e, res_src_e, mem_wr_e, pc_src2_e, alu_control_e,
           alu_src_e, rd1_e, rd2_e, pc_e, imm_e, pc_plus4_e, rs1_e, rs2_e,
           rd_e, op_e, f3_e, rd_w, reg_wr_w, result_w,
    output pc_src, pc_target, reg_wr_m, mem_wr_m, res_src_m, alu_result_m,
           write_data_m, pc_plus4_m, imm_m, rd_m, f3_m
  );
endinterface

// File: rtl/ex_stage.sv
// RV32I execute stage: MEM/WB operand forwarding, ALU, branch/jump resolution,
// fetch redirect and the EX/MEM pipeline register.
module ex_stage #(
  parameter int XLEN    = 32,
  parameter int REGADDR = 5
) (
  input logic       clk,
  input logic       rst_n,
  ex_stage_if.slave bus
);
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic               reg_wr_m_r;
  logic               mem_wr_m_r;
  logic [1:0]         res_src_m_r;
  logic [XLEN-1:0]    alu_result_m_r;
  logic [XLEN-1:0]    write_data_m_r;
  logic [XLEN-1:0]    pc_plus4_m_r;
  logic [XLEN-1:0]    imm_m_r;
  logic [REGADDR-1:0] rd_m_r;
  logic [2:0]         f3_m_r;

  logic [XLEN-1:0]    mem_fwd_s;
  logic               mem_wr_ok_s;
  logic [XLEN-1:0]    src_a_s;
  logic [XLEN-1:0]    fwd_b_s;
  logic [XLEN-1:0]    src_b_s;
  logic [XLEN-1:0]    alu_s;
  logic [XLEN-1:0]    jalr_sum_s;
  logic               branch_taken_s;
  logic               taken_s;
  logic               pc_src_s;
  logic [XLEN-1:0]    pc_target_s;

  function automatic logic fwd_hit(input logic wr, input logic [REGADDR-1:0] rd,
                                   input logic [REGADDR-1:0] rs);
    return wr && (rd != {REGADDR{1'b0}}) && (rd == rs);
  endfunction

  // Loads in MEM have no data yet; the hazard unit keeps dependents out of EX.
  assign mem_wr_ok_s = reg_wr_m_r && (res_src_m_r != 2'b01);

  // Value the instruction currently in MEM will eventually write back
  always_comb begin
    case (res_src_m_r)
      2'b10:   mem_fwd_s = pc_plus4_m_r;
      2'b11:   mem_fwd_s = imm_m_r;
      default: mem_fwd_s = alu_result_m_r;
    endcase
  end

  // Forwarding muxes, MEM before WB before register file
  always_comb begin
    if (fwd_hit(mem_wr_ok_s, rd_m_r, bus.rs1_e)) begin
      src_a_s = mem_fwd_s;
    end else if (fwd_hit(bus.reg_wr_w, bus.rd_w, bus.rs1_e)) begin
      src_a_s = bus.result_w;
    end else begin
      src_a_s = bus.rd1_e;
    end
    if (fwd_hit(mem_wr_ok_s, rd_m_r, bus.rs2_e)) begin
      fwd_b_s = mem_fwd_s;
    end else if (fwd_hit(bus.reg_wr_w, bus.rd_w, bus.rs2_e)) begin
      fwd_b_s = bus.result_w;
    end else begin
      fwd_b_s = bus.rd2_e;
    end
  end

  assign src_b_s = bus.alu_src_e ? bus.imm_e : fwd_b_s;

  // ALU
  always_comb begin
    case (bus.alu_control_e)
      3'b000:  alu_s = src_a_s + src_b_s;
      3'b001:  alu_s = src_a_s - src_b_s;
      3'b010:  alu_s = src_a_s & src_b_s;
      3'b011:  alu_s = src_a_s | src_b_s;
      3'b100:  alu_s = src_a_s ^ src_b_s;
      3'b101:  alu_s = {{(XLEN-1){1'b0}}, $signed(src_a_s) < $signed(src_b_s)};
      3'b110:  alu_s = {{(XLEN-1){1'b0}}, src_a_s < src_b_s};
      3'b111:  alu_s = src_a_s << src_b_s[4:0];
      default: alu_s = {XLEN{1'b0}};
    endcase
  end

  // Branch condition always compares register operands, never the immediate
  always_comb begin
    case (bus.f3_e)
      3'b000:  branch_taken_s = (src_a_s == fwd_b_s);
      3'b001:  branch_taken_s = (src_a_s != fwd_b_s);
      3'b100:  branch_taken_s = ($signed(src_a_s) < $signed(fwd_b_s));
      3'b101:  branch_taken_s = ($signed(src_a_s) >= $signed(fwd_b_s));
      3'b110:  branch_taken_s = (src_a_s < fwd_b_s);
      3'b111:  branch_taken_s = (src_a_s >= fwd_b_s);
      default: branch_taken_s = 1'b0;
    endcase
  end

  // Taken decision by opcode
  always_comb begin
    case (bus.op_e)
      OP_BRANCH:      taken_s = branch_taken_s;
      OP_JAL, OP_JALR: taken_s = 1'b1;
      default:        taken_s = 1'b0;
    endcase
  end

  assign jalr_sum_s = src_a_s + bus.imm_e;

  // Redirect request and target
  always_comb begin
    if (!rst_n) begin
      pc_src_s = 1'b0;
    end else begin
      pc_src_s = taken_s;
    end
    if (bus.pc_src2_e) begin
      pc_target_s = {jalr_sum_s[XLEN-1:1], 1'b0};
    end else begin
      pc_target_s = bus.pc_e + bus.imm_e;
    end
  end

  assign bus.pc_src    = pc_src_s;
  assign bus.pc_target = pc_target_s;

  // EX/MEM register; reset and flush both load an all-zero bubble
  always_ff @(posedge clk) begin
    if (!rst_n || bus.flush_m) begin
      reg_wr_m_r     <= 1'b0;
      mem_wr_m_r     <= 1'b0;
      res_src_m_r    <= 2'b00;
      alu_result_m_r <= {XLEN{1'b0}};
      write_data_m_r <= {XLEN{1'b0}};
      pc_plus4_m_r   <= {XLEN{1'b0}};
      imm_m_r        <= {XLEN{1'b0}};
      rd_m_r         <= {REGADDR{1'b0}};
      f3_m_r         <= 3'b000;
    end else begin
      reg_wr_m_r     <= bus.reg_wr_e;
      mem_wr_m_r     <= bus.mem_wr_e;
      res_src_m_r    <= bus.res_src_e;
      alu_result_m_r <= alu_s;
      write_data_m_r <= fwd_b_s;
      pc_plus4_m_r   <= bus.pc_plus4_e;
      imm_m_r        <= bus.imm_e;
      rd_m_r         <= bus.rd_e;
      f3_m_r         <= bus.f3_e;
    end
  end

  assign bus.reg_wr_m     = reg_wr_m_r;
  assign bus.mem_wr_m     = mem_wr_m_r;
  assign bus.res_src_m    = res_src_m_r;
  assign bus.alu_result_m = alu_result_m_r;
  assign bus.write_data_m = write_data_m_r;
  assign bus.pc_plus4_m   = pc_plus4_m_r;
  assign bus.imm_m        = imm_m_r;
  assign bus.rd_m         = rd_m_r;
  assign bus.f3_m         = f3_m_r;
endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases with literal expectations,
// then randomized instructions checked against a behavioural model every cycle.
module tb_ex_stage;
  logic clk;
  logic rst_n;
  ex_stage_if bus ();

  ex_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        reg_wr;
    logic        mem_wr;
    logic [1:0]  res_src;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [2:0]  f3;
  } exmem_t;

  exmem_t      cur, nxt;
  logic        exp_pc_src;
  logic [31:0] exp_pc_target;
  bit          check_en;
  int          vectors;
  int          miscompares;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // What the architectural register X reads as, given MEM/WB in flight
  function automatic logic [31:0] reg_value(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 5'd0) return rf;
    if (cur.reg_wr && cur.rd == idx && cur.res_src != 2'b01) begin
      if (cur.res_src == 2'b10) return cur.pc4;
      if (cur.res_src == 2'b11) return cur.imm;
      return cur.alu;
    end
    if (bus.reg_wr_w && bus.rd_w == idx) return bus.result_w;
    return rf;
  endfunction

  task automatic model_eval();
    logic [31:0] a, b, rs2v, r;
    logic        tk;
    int          sa, sb;
    a    = reg_value(bus.rs1_e, bus.rd1_e);
    rs2v = reg_value(bus.rs2_e, bus.rd2_e);
    b    = bus.alu_src_e ? bus.imm_e : rs2v;
    sa = int'(a);
    sb = int'(b);
    case (bus.alu_control_e)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = (sa < sb) ? 32'd1 : 32'd0;
      3'd6: r = (a < b) ? 32'd1 : 32'd0;
      default: r = a << b[4:0];
    endcase
    sa = int'(a);
    sb = int'(rs2v);
    tk = 1'b0;
    if (bus.op_e == 7'b1101111 || bus.op_e == 7'b1100111) tk = 1'b1;
    else if (bus.op_e == 7'b1100011) begin
      if (bus.f3_e == 3'd0) tk = (a == rs2v);
      else if (bus.f3_e == 3'd1) tk = (a != rs2v);
      else if (bus.f3_e == 3'd4) tk = (sa < sb);
      else if (bus.f3_e == 3'd5) tk = (sa >= sb);
      else if (bus.f3_e == 3'd6) tk = (a < rs2v);
      else if (bus.f3_e == 3'd7) tk = (a >= rs2v);
    end
    exp_pc_src    = rst_n ? tk : 1'b0;
    exp_pc_target = bus.pc_src2_e ? ((a + bus.imm_e) & 32'hffff_fffe) : (bus.pc_e + bus.imm_e);
    nxt = '{1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 3'd0};
    if (rst_n && !bus.flush_m)
      nxt = '{bus.reg_wr_e, bus.mem_wr_e, bus.res_src_e, r, rs2v,
              bus.pc_plus4_e, bus.imm_e, bus.rd_e, bus.f3_e};
  endtask

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin
    if (check_en) begin
      cmp("pc_src", {31'd0, bus.pc_src}, {31'd0, exp_pc_src});
      cmp("pc_target", bus.pc_target, exp_pc_target);
      cmp("reg_wr_m", {31'd0, bus.reg_wr_m}, {31'd0, cur.reg_wr});
      cmp("mem_wr_m", {31'd0, bus.mem_wr_m}, {31'd0, cur.mem_wr});
      cmp("res_src_m", {30'd0, bus.res_src_m}, {30'd0, cur.res_src});
      cmp("alu_result_m", bus.alu_result_m, cur.alu);
      cmp("write_data_m", bus.write_data_m, cur.wd);
      cmp("pc_plus4_m", bus.pc_plus4_m, cur.pc4);
      cmp("imm_m", bus.imm_m, cur.imm);
      cmp("rd_m", {27'd0, bus.rd_m}, {27'd0, cur.rd});
      cmp("f3_m", {29'd0, bus.f3_m}, {29'd0, cur.f3});
    end
  end

  task automatic idle();
    bus.flush_m = 1'b0; bus.reg_wr_e = 1'b0; bus.res_src_e = 2'd0; bus.mem_wr_e = 1'b0;
    bus.pc_src2_e = 1'b0; bus.alu_control_e = 3'd0; bus.alu_src_e = 1'b0;
    bus.rd1_e = 32'd0; bus.rd2_e = 32'd0; bus.pc_e = 32'd0; bus.imm_e = 32'd0;
    bus.pc_plus4_e = 32'd0; bus.rs1_e = 5'd0; bus.rs2_e = 5'd0; bus.rd_e = 5'd0;
    bus.op_e = 7'b0110011; bus.f3_e = 3'd0; bus.rd_w = 5'd0; bus.reg_wr_w = 1'b0;
    bus.result_w = 32'd0;
  endtask

  task automatic apply();
    model_eval();
    @(posedge clk);
    #1;
    cur = nxt;
  endtask

  initial begin
    logic [6:0] ops [8];
    vectors = 0;
    miscompares = 0;
    check_en = 1'b0;
    cur = '{1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 3'd0};
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
            7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
    idle();
    rst_n = 1'b0;
    bus.reg_wr_e = 1'b1; bus.rd_e = 5'd3; bus.rd1_e = 32'h55; bus.op_e = 7'b1101111;
    @(posedge clk);
    #1;
    apply();
    check_en = 1'b1;
    #1 cmp("rst_pc_src", {31'd0, bus.pc_src}, 32'd0);
    apply();
    cmp("rst_reg_wr_m", {31'd0, bus.reg_wr_m}, 32'd0);
    cmp("rst_alu_result_m", bus.alu_result_m, 32'd0);
    cmp("rst_rd_m", {27'd0, bus.rd_m}, 32'd0);

    // MEM beats WB for x5
    rst_n = 1'b1;
    idle();
    bus.reg_wr_e = 1'b1; bus.rd_e = 5'd5; bus.rd1_e = 32'd7;
    apply();
    idle();
    bus.reg_wr_e = 1'b1; bus.rd_e = 5'd6; bus.rs1_e = 5'd5; bus.rs2_e = 5'd5;
    bus.rd1_e = 32'd1; bus.rd2_e = 32'd1;
    bus.rd_w = 5'd5; bus.reg_wr_w = 1'b1; bus.result_w = 32'd9;
    apply();
    cmp("prio_alu_result_m", bus.alu_result_m, 32'd14);

    // x0 never forwards
    idle();
    bus.reg_wr_e = 1'b1; bus.rd_e = 5'd0; bus.rd1_e = 32'd5;
    apply();
    cmp("x0_setup_alu", bus.alu_result_m, 32'd5);
    idle();
    bus.reg_wr_e = 1'b1; bus.rd_e = 5'd7; bus.alu_src_e = 1'b1; bus.imm_e = 32'd3;
    bus.op_e = 7'b0010011; bus.rd_w = 5'd0; bus.reg_wr_w = 1'b1; bus.result_w = 32'd99;
    apply();
    cmp("x0_alu_result_m", bus.alu_result_m, 32'd3);

    // Branches
    idle();
    bus.op_e = 7'b1100011; bus.rs1_e = 5'd1; bus.rs2_e = 5'd2;
    bus.rd1_e = 32'h10; bus.rd2_e = 32'h10; bus.pc_e = 32'h40; bus.imm_e = 32'd8;
    #1 cmp("beq_pc_src", {31'd0, bus.pc_src}, 32'd1);
    cmp("beq_pc_target", bus.pc_target, 32'h48);
    apply();
    bus.f3_e = 3'b100; bus.rd1_e = 32'hffff_ffff; bus.rd2_e = 32'd1;
    #1 cmp("blt_pc_src", {31'd0, bus.pc_src}, 32'd1);
    apply();
    bus.f3_e = 3'b110;
    #1 cmp("bltu_pc_src", {31'd0, bus.pc_src}, 32'd0);
    apply();

    // Jumps
    idle();
    bus.op_e = 7'b1100111; bus.pc_src2_e = 1'b1; bus.rs1_e = 5'd1; bus.rd1_e = 32'h101;
    bus.imm_e = 32'd4; bus.alu_src_e = 1'b1;
    #1 cmp("jalr_pc_src", {31'd0, bus.pc_src}, 32'd1);
    cmp("jalr_pc_target", bus.pc_target, 32'h104);
    apply();
    idle();
    bus.op_e = 7'b1101111; bus.reg_wr_e = 1'b1; bus.res_src_e = 2'b10; bus.rd_e = 5'd1;
    bus.pc_plus4_e = 32'h24; bus.pc_e = 32'h20; bus.imm_e = 32'h100;
    apply();
    cmp("jal_pc_plus4_m", bus.pc_plus4_m, 32'h24);
    cmp("jal_res_src_m", {30'd0, bus.res_src_m}, 32'd2);

    // Flush, then the same store captured normally
    idle();
    bus.op_e = 7'b0100011; bus.mem_wr_e = 1'b1; bus.alu_src_e = 1'b1; bus.f3_e = 3'b010;
    bus.rs1_e = 5'd2; bus.rs2_e = 5'd3; bus.rd1_e = 32'h1000; bus.rd2_e = 32'hcafe; bus.imm_e = 32'd8;
    bus.flush_m = 1'b1;
    apply();
    cmp("flush_mem_wr_m", {31'd0, bus.mem_wr_m}, 32'd0);
    cmp("flush_alu_result_m", bus.alu_result_m, 32'd0);
    bus.flush_m = 1'b0;
    apply();
    cmp("store_mem_wr_m", {31'd0, bus.mem_wr_m}, 32'd1);
    cmp("store_alu_result_m", bus.alu_result_m, 32'h1008);
    cmp("store_write_data_m", bus.write_data_m, 32'hcafe);

    // Randomized instruction stream
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 39) != 0);
      bus.flush_m = ($urandom_range(0, 7) == 0);
      bus.op_e = ops[$urandom_range(0, 7)];
      bus.reg_wr_e = $urandom_range(0, 1);
      bus.res_src_e = 2'($urandom_range(0, 3));
      bus.mem_wr_e = (bus.op_e == 7'b0100011);
      bus.pc_src2_e = (bus.op_e == 7'b1100111);
      bus.alu_control_e = 3'($urandom_range(0, 7));
      bus.alu_src_e = $urandom_range(0, 1);
      bus.rd1_e = ($urandom_range(0, 3) == 0) ? 32'hffff_fff0 + 32'($urandom_range(0, 15)) : $urandom;
      bus.rd2_e = ($urandom_range(0, 3) == 0) ? bus.rd1_e : $urandom;
      bus.pc_e = $urandom & 32'hffff_fffc;
      bus.pc_plus4_e = bus.pc_e + 32'd4;
      bus.imm_e = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : $urandom;
      bus.rs1_e = 5'($urandom_range(0, 7));
      bus.rs2_e = 5'($urandom_range(0, 7));
      bus.rd_e = 5'($urandom_range(0, 7));
      bus.f3_e = 3'($urandom_range(0, 7));
      bus.rd_w = 5'($urandom_range(0, 7));
      bus.reg_wr_w = $urandom_range(0, 1);
      bus.result_w = $urandom;
      // the hazard unit never lets a load's dependent into EX
      if (cur.reg_wr && cur.res_src == 2'b01 && cur.rd != 5'd0) begin
        if (bus.rs1_e == cur.rd) bus.rs1_e = cur.rd ^ 5'd8;
        if (bus.rs2_e == cur.rd) bus.rs2_e = cur.rd ^ 5'd8;
      end
      apply();
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
